// File: rtl/fifo_stream_reader_pkg.sv
// Shared sizing helpers for the FIFO read-side stream adapter.
package fifo_stream_reader_pkg;

   localparam int MAX_RD_LAT = 4;
   // Wide enough to hold a popcount of the deepest supported in-flight tracker.
   localparam int TRK_CNT_W  = $clog2(MAX_RD_LAT + 1);

   function automatic int clog2_p1(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/reader_skid_buf.sv
// Small circular buffer holding words returned by the FIFO RAM until the
// downstream stream accepts them.
module reader_skid_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3,
   localparam int LW   = clog2_p1(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rd_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   // Depth need not be a power of two: the address wraps at DEPTH-1 and the
   // extra MSB toggles, so equal addresses with differing MSBs means full.
   function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
      if (p[AW-1:0] == AW'(DEPTH - 1)) begin
         return {~p[AW], {AW{1'b0}}};
      end
      return p + PTR_ONE;
   endfunction

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign do_wr   = wr_i && !full_o;
   assign do_rd   = rd_i && !empty_o;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      level_o = LW'(int'(wptr_q[AW-1:0]) - int'(rptr_q[AW-1:0])
                    + ((wptr_q[AW] != rptr_q[AW]) ? DEPTH : 0));
   end

   always_comb begin
      wptr_d = do_wr ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = do_rd ? ptr_inc(rptr_q) : rptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Converts the dual-clock FIFO pop interface into a valid/ready stream,
// crediting in-flight RAM reads so back-pressure never overruns the buffer.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int RD_LAT    = 1,
   parameter int BUF_DEPTH = RD_LAT + 2,
   parameter int PKT_LEN   = 0,
   parameter int CNTW      = 16
) (
   input  logic                             rdclk,
   input  logic                             reset,
   output logic                             fifo_rd,
   input  logic                             fifo_empty,
   input  logic [WIDTH-1:0]                 fifo_dout,
   output logic [WIDTH-1:0]                 m_data,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             m_last,
   output logic [CNTW-1:0]                  beat_cnt,
   output logic [clog2_p1(BUF_DEPTH)-1:0]   level,
   output logic                             err_ovf
);

   localparam int LW = clog2_p1(BUF_DEPTH);
   localparam int CW = ((LW + 1) > TRK_CNT_W) ? (LW + 1) : TRK_CNT_W;
   localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   logic [RD_LAT-1:0]    trk_q, trk_d;
   logic [TRK_CNT_W-1:0] inflight;
   logic                 land, beat, buf_full, buf_empty;
   logic                 err_q, err_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + TRK_CNT_W'(trk_q[i]);
      end
   end

   // Credit check counts only what is already held or owed; a beat leaving
   // this cycle is not counted, which keeps the check free of m_ready.
   assign fifo_rd = !reset && !fifo_empty &&
                    ((CW'(level) + CW'(inflight)) < CW'(BUF_DEPTH));

   always_comb begin
      trk_d    = '0;
      trk_d[0] = fifo_rd;
      for (int i = 1; i < RD_LAT; i++) begin
         trk_d[i] = trk_q[i-1];
      end
   end

   assign land    = trk_q[RD_LAT-1];
   assign m_valid = !buf_empty;
   assign beat    = m_valid && m_ready;

   reader_skid_buf #(
      .WIDTH (WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk     (rdclk),
      .rst     (reset),
      .wr_i    (land),
      .wdata_i (fifo_dout),
      .rd_i    (beat),
      .rdata_o (m_data),
      .full_o  (buf_full),
      .empty_o (buf_empty),
      .level_o (level)
   );

   always_comb begin
      err_d = err_q || (land && buf_full);
      cnt_d = beat ? (cnt_q + CNTW'(1)) : cnt_q;
      idx_d = idx_q;
      if (beat && (PKT_LEN != 0)) begin
         idx_d = (idx_q == IW'(PKT_LEN - 1)) ? '0 : (idx_q + IW'(1));
      end
   end

   assign m_last   = (PKT_LEN != 0) && m_valid && (idx_q == IW'(PKT_LEN - 1));
   assign beat_cnt = cnt_q;
   assign err_ovf  = err_q;

   always_ff @(posedge rdclk) begin
      if (reset) begin
         trk_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         trk_q <= trk_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two instances (RD_LAT=1/PKT_LEN=4 and
// RD_LAT=3/BUF_DEPTH=5) fed by a behavioural FIFO with read pipeline.
module tb_fifo_stream_reader;

   localparam int LAT0 = 1;
   localparam int DEP0 = 3;
   localparam int LAT1 = 3;
   localparam int DEP1 = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s   [2];
   logic       rd_s    [2];
   logic       empty_s [2];
   logic       vld_s   [2];
   logic       rdy_s   [2];
   logic       last_s  [2];
   logic       ovf_s   [2];
   logic [7:0] dout_s  [2];
   logic [7:0] dat_s   [2];
   logic [15:0] cnt_s  [2];
   logic [1:0] lvl0;
   logic [2:0] lvl1;

   fifo_stream_reader #(.WIDTH(8), .RD_LAT(LAT0), .BUF_DEPTH(DEP0), .PKT_LEN(4), .CNTW(16)) dut0 (
      .rdclk(clk), .reset(rst_s[0]), .fifo_rd(rd_s[0]), .fifo_empty(empty_s[0]),
      .fifo_dout(dout_s[0]), .m_data(dat_s[0]), .m_valid(vld_s[0]), .m_ready(rdy_s[0]),
      .m_last(last_s[0]), .beat_cnt(cnt_s[0]), .level(lvl0), .err_ovf(ovf_s[0]));

   fifo_stream_reader #(.WIDTH(8), .RD_LAT(LAT1), .BUF_DEPTH(DEP1), .PKT_LEN(0), .CNTW(16)) dut1 (
      .rdclk(clk), .reset(rst_s[1]), .fifo_rd(rd_s[1]), .fifo_empty(empty_s[1]),
      .fifo_dout(dout_s[1]), .m_data(dat_s[1]), .m_valid(vld_s[1]), .m_ready(rdy_s[1]),
      .m_last(last_s[1]), .beat_cnt(cnt_s[1]), .level(lvl1), .err_ovf(ovf_s[1]));

   int compared   = 0;
   int mismatched = 0;
   int cycle      = 0;

   logic [7:0] src [2][$];
   logic [7:0] exq [2][$];
   logic [7:0] pipe [2][4];
   logic       force_empty [2];
   logic       obs_vld [2], obs_beat [2], obs_last [2], obs_pop [2];
   logic [7:0] obs_data [2];
   int         rd_while_empty [2];

   function automatic int lvl(input int d);
      return (d == 0) ? int'(lvl0) : int'(lvl1);
   endfunction

   // One clock of the FIFO model: sample pre-edge, then advance the RAM pipe.
   task automatic step();
      for (int d = 0; d < 2; d++) empty_s[d] = (src[d].size() == 0) || force_empty[d];
      #1;
      for (int d = 0; d < 2; d++) begin
         obs_vld[d]  = vld_s[d];
         obs_beat[d] = vld_s[d] && rdy_s[d];
         obs_data[d] = dat_s[d];
         obs_last[d] = last_s[d];
         obs_pop[d]  = rd_s[d] && !empty_s[d];
         if (rd_s[d] && empty_s[d]) rd_while_empty[d]++;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int i = 3; i > 0; i--) pipe[d][i] = pipe[d][i-1];
         pipe[d][0] = obs_pop[d] ? src[d].pop_front() : 8'($urandom);
         dout_s[d]  = pipe[d][((d == 0) ? LAT0 : LAT1) - 1];
      end
      cycle++;
   endtask

   task automatic hold_reset(input int d);
      rst_s[d] = 1'b1;
      src[d].delete();
      exq[d].delete();
      force_empty[d] = 1'b0;
      rdy_s[d] = 1'b0;
      rd_while_empty[d] = 0;
      step();
      step();
   endtask

   task automatic push(input int d, input logic [7:0] w);
      src[d].push_back(w);
      exq[d].push_back(w);
   endtask

   task automatic test_reset();
      rst_s[0] = 1'b1; rst_s[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin src[d].push_back(8'h55); src[d].push_back(8'h66); end
      step(); step();
      for (int d = 0; d < 2; d++) begin
         compared++; if (vld_s[d] !== 1'b0) begin mismatched++; $display("FAIL reset_valid d%0d: got %b want 0", d, vld_s[d]); end
         compared++; if (lvl(d) != 0) begin mismatched++; $display("FAIL reset_level d%0d: got %0d want 0", d, lvl(d)); end
         compared++; if (cnt_s[d] !== 16'd0) begin mismatched++; $display("FAIL reset_beat_cnt d%0d: got %0d want 0", d, cnt_s[d]); end
         compared++; if (ovf_s[d] !== 1'b0) begin mismatched++; $display("FAIL reset_err_ovf d%0d: got %b want 0", d, ovf_s[d]); end
         compared++; if (last_s[d] !== 1'b0) begin mismatched++; $display("FAIL reset_last d%0d: got %b want 0", d, last_s[d]); end
         compared++; if (rd_s[d] !== 1'b0) begin mismatched++; $display("FAIL reset_fifo_rd d%0d: got %b want 0", d, rd_s[d]); end
      end
      src[0].delete(); src[1].delete();
   endtask

   task automatic test_drain();
      int n, first, lastc;
      logic [7:0] e;
      hold_reset(0);
      for (int i = 0; i < 8; i++) push(0, 8'(8'h10 + i));
      rdy_s[0] = 1'b1;
      step();
      rst_s[0] = 1'b0;
      step();
      compared++; if (vld_s[0] !== 1'b0) begin mismatched++; $display("FAIL drain_early_valid: got %b want 0", vld_s[0]); end
      step();
      compared++; if (vld_s[0] !== 1'b1) begin mismatched++; $display("FAIL drain_first_valid: got %b want 1", vld_s[0]); end
      n = 0; first = -1; lastc = -1;
      for (int c = 0; c < 30 && exq[0].size() > 0; c++) begin
         step();
         if (obs_beat[0]) begin
            e = exq[0].pop_front();
            compared++; if (obs_data[0] !== e) begin mismatched++; $display("FAIL drain_data: got %h want %h", obs_data[0], e); end
            if (first < 0) first = cycle;
            lastc = cycle;
            n++;
         end
      end
      compared++; if (n != 8) begin mismatched++; $display("FAIL drain_count: got %0d want 8", n); end
      compared++; if (lastc - first != 7) begin mismatched++; $display("FAIL drain_contiguous: got span %0d want 7", lastc - first); end
      compared++; if (cnt_s[0] !== 16'd8) begin mismatched++; $display("FAIL drain_beat_cnt: got %0d want 8", cnt_s[0]); end
      compared++; if (ovf_s[0] !== 1'b0) begin mismatched++; $display("FAIL drain_err_ovf: got %b want 0", ovf_s[0]); end
   endtask

   task automatic test_backpressure();
      int npop, n, first, lastc;
      logic [7:0] e;
      hold_reset(0);
      for (int i = 0; i < 20; i++) push(0, 8'(8'h40 + i));
      rst_s[0] = 1'b0;
      npop = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (obs_pop[0]) npop++;
         if (obs_vld[0]) begin
            compared++; if (obs_data[0] !== 8'h40) begin mismatched++; $display("FAIL bp_data_stable: got %h want 40", obs_data[0]); end
         end
      end
      compared++; if (npop != DEP0) begin mismatched++; $display("FAIL bp_pop_count: got %0d want %0d", npop, DEP0); end
      compared++; if (lvl(0) != DEP0) begin mismatched++; $display("FAIL bp_level: got %0d want %0d", lvl(0), DEP0); end
      compared++; if (rd_s[0] !== 1'b0) begin mismatched++; $display("FAIL bp_fifo_rd: got %b want 0", rd_s[0]); end
      rdy_s[0] = 1'b1;
      n = 0; first = -1; lastc = -1;
      for (int c = 0; c < 40 && exq[0].size() > 0; c++) begin
         step();
         if (obs_beat[0]) begin
            e = exq[0].pop_front();
            compared++; if (obs_data[0] !== e) begin mismatched++; $display("FAIL bp_data: got %h want %h", obs_data[0], e); end
            if (first < 0) first = cycle;
            lastc = cycle;
            n++;
         end
      end
      compared++; if (n != 20) begin mismatched++; $display("FAIL bp_count: got %0d want 20", n); end
      compared++; if (lastc - first != 19) begin mismatched++; $display("FAIL bp_no_gaps: got span %0d want 19", lastc - first); end
   endtask

   task automatic test_empty_toggle();
      int n;
      logic [7:0] e;
      hold_reset(0);
      for (int i = 0; i < 12; i++) push(0, 8'(8'h80 + 3 * i));
      rdy_s[0] = 1'b1;
      rst_s[0] = 1'b0;
      n = 0;
      for (int c = 0; c < 80 && exq[0].size() > 0; c++) begin
         force_empty[0] = ~force_empty[0];
         step();
         if (obs_beat[0]) begin
            e = exq[0].pop_front();
            compared++; if (obs_data[0] !== e) begin mismatched++; $display("FAIL toggle_data: got %h want %h", obs_data[0], e); end
            n++;
         end
      end
      force_empty[0] = 1'b0;
      compared++; if (n != 12) begin mismatched++; $display("FAIL toggle_count: got %0d want 12", n); end
      compared++; if (rd_while_empty[0] != 0) begin mismatched++; $display("FAIL toggle_rd_while_empty: got %0d want 0", rd_while_empty[0]); end
   endtask

   task automatic test_packets();
      int n, idx;
      logic pv, pb, pl;
      logic [7:0] pd, e;
      hold_reset(0);
      for (int i = 0; i < 60; i++) push(0, 8'(i));
      rdy_s[0] = 1'b1;
      rst_s[0] = 1'b0;
      n = 0; idx = 0; pv = 1'b0; pb = 1'b0; pl = 1'b0; pd = '0;
      for (int c = 0; c < 100 && n < 30; c++) begin
         if (n >= 10) rdy_s[0] = ($urandom_range(0, 1) == 1);
         step();
         if (pv && !pb) begin
            compared++; if (obs_vld[0] !== 1'b1 || obs_data[0] !== pd || obs_last[0] !== pl) begin
               mismatched++; $display("FAIL pkt_hold: got v%b d%h l%b want v1 d%h l%b", obs_vld[0], obs_data[0], obs_last[0], pd, pl);
            end
         end
         if (obs_vld[0]) begin
            compared++; if (obs_last[0] !== (idx == 3)) begin mismatched++; $display("FAIL pkt_last beat%0d: got %b want %b", n + 1, obs_last[0], (idx == 3)); end
         end
         if (obs_beat[0]) begin
            e = exq[0].pop_front();
            compared++; if (obs_data[0] !== e) begin mismatched++; $display("FAIL pkt_data: got %h want %h", obs_data[0], e); end
            idx = (idx + 1) % 4;
            n++;
         end
         pv = obs_vld[0]; pb = obs_beat[0]; pl = obs_last[0]; pd = obs_data[0];
      end
      compared++; if (n != 30) begin mismatched++; $display("FAIL pkt_count: got %0d want 30", n); end
   endtask

   task automatic test_mid_reset();
      int nv;
      logic [7:0] e;
      hold_reset(0);
      for (int i = 0; i < 20; i++) push(0, 8'(8'hc0 + i));
      rdy_s[0] = 1'b1;
      rst_s[0] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (obs_beat[0]) begin
            e = exq[0].pop_front();
            compared++; if (obs_data[0] !== e) begin mismatched++; $display("FAIL midrst_data: got %h want %h", obs_data[0], e); end
         end
      end
      rdy_s[0] = 1'b0;
      step();
      compared++; if (lvl(0) != 2) begin mismatched++; $display("FAIL midrst_pre_level: got %0d want 2", lvl(0)); end
      compared++; if (cnt_s[0] !== 16'd2) begin mismatched++; $display("FAIL midrst_pre_cnt: got %0d want 2", cnt_s[0]); end
      rst_s[0] = 1'b1;
      src[0].delete(); exq[0].delete();
      step();
      rst_s[0] = 1'b0;
      compared++; if (vld_s[0] !== 1'b0) begin mismatched++; $display("FAIL midrst_valid: got %b want 0", vld_s[0]); end
      compared++; if (lvl(0) != 0) begin mismatched++; $display("FAIL midrst_level: got %0d want 0", lvl(0)); end
      compared++; if (cnt_s[0] !== 16'd0) begin mismatched++; $display("FAIL midrst_cnt: got %0d want 0", cnt_s[0]); end
      // Long-latency instance: reset while three reads are still in the pipe.
      hold_reset(1);
      for (int i = 0; i < 20; i++) push(1, 8'(8'he0 + i));
      rst_s[1] = 1'b0;
      step(); step(); step();
      rst_s[1] = 1'b1;
      src[1].delete(); exq[1].delete();
      step();
      rst_s[1] = 1'b0;
      rdy_s[1] = 1'b1;
      rdy_s[0] = 1'b1;
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (obs_vld[0] || obs_vld[1]) nv++;
      end
      compared++; if (nv != 0) begin mismatched++; $display("FAIL midrst_late_word: got %0d valid cycles want 0", nv); end
      compared++; if (lvl(1) != 0) begin mismatched++; $display("FAIL midrst_late_level: got %0d want 0", lvl(1)); end
   endtask

   task automatic test_stress();
      logic [7:0] seq, e;
      seq = 8'h00;
      hold_reset(1);
      rst_s[1] = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         while (src[1].size() < 3) begin push(1, seq); seq++; end
         rdy_s[1] = ($urandom_range(0, 3) != 0);
         force_empty[1] = ($urandom_range(0, 3) == 0);
         step();
         if (obs_beat[1]) begin
            compared++;
            if (exq[1].size() == 0) begin mismatched++; $display("FAIL stress_extra_beat: got %h want none", obs_data[1]); end
            else begin
               e = exq[1].pop_front();
               if (obs_data[1] !== e) begin mismatched++; $display("FAIL stress_data: got %h want %h", obs_data[1], e); end
            end
         end
      end
      force_empty[1] = 1'b0;
      rdy_s[1] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         while (src[1].size() < 3) begin push(1, seq); seq++; end
         step();
         if (obs_beat[1] && exq[1].size() > 0) begin
            e = exq[1].pop_front();
            compared++; if (obs_data[1] !== e) begin mismatched++; $display("FAIL stress_tp_data: got %h want %h", obs_data[1], e); end
         end
         if (c >= 8) begin
            compared++; if (obs_beat[1] !== 1'b1) begin mismatched++; $display("FAIL stress_throughput c%0d: got %b want 1", c, obs_beat[1]); end
         end
      end
      compared++; if (ovf_s[1] !== 1'b0) begin mismatched++; $display("FAIL stress_err_ovf: got %b want 0", ovf_s[1]); end
      compared++; if (rd_while_empty[1] != 0) begin mismatched++; $display("FAIL stress_rd_while_empty: got %0d want 0", rd_while_empty[1]); end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; rdy_s[d] = 1'b0; empty_s[d] = 1'b1; dout_s[d] = '0;
         force_empty[d] = 1'b0; rd_while_empty[d] = 0;
         for (int i = 0; i < 4; i++) pipe[d][i] = '0;
      end
      #2;
      test_reset();
      test_drain();
      test_backpressure();
      test_empty_toggle();
      test_packets();
      test_mid_reset();
      test_stress();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
